// File: rtl/vanilla_exe_bubble_profiler_pkg.sv
// rtl/vanilla_exe_bubble_profiler_pkg.sv - shared types and cause indices for the EXE bubble profiler
package vanilla_exe_bubble_profiler_pkg;

    typedef enum logic {
        e_dump_idle,
        e_dump_active
    } dump_state_e;

    // Canonical cause indices, kept in step with the trace printer
    localparam int e_cause_branch_miss       = 0;
    localparam int e_cause_jalr_miss         = 1;
    localparam int e_cause_icache_miss       = 2;
    localparam int e_cause_stall_depend_dram = 3;
    localparam int e_cause_stall_depend_long = 4;
    localparam int e_cause_stall_fence       = 5;
    localparam int e_cause_stall_md          = 6;
    localparam int e_cause_stall_fcsr        = 7;

endpackage

// File: rtl/vanilla_bubble_cause_counters.sv
// rtl/vanilla_bubble_cause_counters.sv - per-cause saturating counters with valid/yumi dump port
module vanilla_bubble_cause_counters
    import vanilla_exe_bubble_profiler_pkg::*;
#(
    parameter int num_cause_p = 24,
    parameter int ctr_width_p = 32,
    localparam int cause_width_lp = $clog2(num_cause_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      inc_v_i,
    input  logic [cause_width_lp-1:0] inc_cause_i,
    input  logic                      dump_req_i,
    input  logic                      dump_clear_i,
    output logic                      dump_busy_o,
    output logic                      dump_v_o,
    output logic [cause_width_lp-1:0] dump_cause_o,
    output logic [ctr_width_p-1:0]    dump_count_o,
    input  logic                      dump_yumi_i
);

    dump_state_e               state_r, state_n;
    logic [cause_width_lp-1:0] idx_r, idx_n;
    logic                      clear_r, clear_n;
    logic [ctr_width_p-1:0]    ctr_w [num_cause_p];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= e_dump_idle;
            idx_r   <= '0;
            clear_r <= 1'b0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            clear_r <= clear_n;
        end
    end

    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        clear_n = clear_r;
        case (state_r)
            e_dump_idle: begin
                if (dump_req_i) begin
                    state_n = e_dump_active;
                    idx_n   = '0;
                    clear_n = dump_clear_i;
                end
            end
            e_dump_active: begin
                if (dump_yumi_i) begin
                    if (idx_r == cause_width_lp'(num_cause_p - 1)) begin
                        state_n = e_dump_idle;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_r + cause_width_lp'(1);
                    end
                end
            end
            default: state_n = e_dump_idle;
        endcase
    end

    for (genvar k = 0; k < num_cause_p; k++) begin : g_ctr
        logic                   inc_hit;
        logic                   clr_hit;
        logic [ctr_width_p-1:0] ctr_q;

        assign inc_hit  = inc_v_i && (inc_cause_i == cause_width_lp'(k));
        assign clr_hit  = dump_yumi_i && clear_r && (state_r == e_dump_active)
                          && (idx_r == cause_width_lp'(k));
        assign ctr_w[k] = ctr_q;

        // A clear that coincides with an increment keeps that one event
        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                ctr_q <= '0;
            end else if (clr_hit) begin
                ctr_q <= inc_hit ? ctr_width_p'(1) : '0;
            end else if (inc_hit && !(&ctr_q)) begin
                ctr_q <= ctr_q + ctr_width_p'(1);
            end
        end
    end

    assign dump_busy_o  = (state_r == e_dump_active);
    assign dump_v_o     = (state_r == e_dump_active);
    assign dump_cause_o = (state_r == e_dump_active) ? idx_r : '0;
    assign dump_count_o = (state_r == e_dump_active) ? ctr_w[idx_r] : '0;

endmodule

// File: rtl/vanilla_exe_bubble_profiler.sv
// rtl/vanilla_exe_bubble_profiler.sv - two-stage EXE bubble classifier with per-cause counters
module vanilla_exe_bubble_profiler
    import vanilla_exe_bubble_profiler_pkg::*;
#(
    parameter int pc_width_p  = 32,
    parameter int num_cause_p = 24,
    parameter int ctr_width_p = 32,
    localparam int cause_width_lp = $clog2(num_cause_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      stall_all_i,
    input  logic                      exe_redirect_v_i,
    input  logic [cause_width_lp-1:0] exe_redirect_cause_i,
    input  logic [pc_width_p-1:0]     exe_pc_i,
    input  logic                      front_bubble_v_i,
    input  logic [cause_width_lp-1:0] front_bubble_cause_i,
    input  logic [pc_width_p-1:0]     front_bubble_pc_i,
    input  logic [num_cause_p-1:0]    id_stall_i,
    input  logic [pc_width_p-1:0]     id_pc_i,
    output logic                      exe_bubble_v_o,
    output logic [cause_width_lp-1:0] exe_bubble_cause_o,
    output logic [pc_width_p-1:0]     exe_bubble_pc_o,
    input  logic                      dump_req_i,
    input  logic                      dump_clear_i,
    output logic                      dump_busy_o,
    output logic                      dump_v_o,
    output logic [cause_width_lp-1:0] dump_cause_o,
    output logic [ctr_width_p-1:0]    dump_count_o,
    input  logic                      dump_yumi_i
);

    typedef struct packed {
        logic                      v;
        logic [cause_width_lp-1:0] cause;
        logic [pc_width_p-1:0]     pc;
    } bubble_info_s;

    bubble_info_s              id_r, id_n, exe_r, exe_n;
    logic [cause_width_lp-1:0] stall_cause;

    // Descending scan so the lowest set stall bit is the one left standing
    always_comb begin
        stall_cause = '0;
        for (int k = num_cause_p - 1; k >= 0; k--) begin
            if (id_stall_i[k]) stall_cause = cause_width_lp'(k);
        end
    end

    always_comb begin
        id_n  = '0;
        exe_n = '0;
        if (exe_redirect_v_i) begin
            id_n = '{v: 1'b1, cause: exe_redirect_cause_i, pc: exe_pc_i};
        end else if (front_bubble_v_i) begin
            id_n = '{v: 1'b1, cause: front_bubble_cause_i, pc: front_bubble_pc_i};
        end
        if (exe_redirect_v_i) begin
            exe_n = '{v: 1'b1, cause: exe_redirect_cause_i, pc: exe_pc_i};
        end else if (id_r.v) begin
            exe_n = id_r;
        end else if (|id_stall_i) begin
            exe_n = '{v: 1'b1, cause: stall_cause, pc: id_pc_i};
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            id_r  <= '0;
            exe_r <= '0;
        end else if (!stall_all_i) begin
            id_r  <= id_n;
            exe_r <= exe_n;
        end
    end

    assign exe_bubble_v_o     = exe_r.v;
    assign exe_bubble_cause_o = exe_r.cause;
    assign exe_bubble_pc_o    = exe_r.pc;

    vanilla_bubble_cause_counters #(
        .num_cause_p(num_cause_p),
        .ctr_width_p(ctr_width_p)
    ) counters (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .inc_v_i     (exe_r.v && !stall_all_i),
        .inc_cause_i (exe_r.cause),
        .dump_req_i  (dump_req_i),
        .dump_clear_i(dump_clear_i),
        .dump_busy_o (dump_busy_o),
        .dump_v_o    (dump_v_o),
        .dump_cause_o(dump_cause_o),
        .dump_count_o(dump_count_o),
        .dump_yumi_i (dump_yumi_i)
    );

endmodule

// File: tb/tb_vanilla_exe_bubble_profiler.sv
// tb/tb_vanilla_exe_bubble_profiler.sv - self-checking bench for the EXE bubble profiler
module tb_vanilla_exe_bubble_profiler;

    localparam int NC  = 24;
    localparam int PCW = 32;
    localparam int CW  = 4;
    localparam int CAW = 5;
    localparam int SAT = 15;

    logic           clk = 1'b0;
    logic           reset_ni = 1'b0;
    logic           stall_all, redir_v, front_v, dump_req, dump_clear, dump_yumi;
    logic [CAW-1:0] redir_cause, front_cause;
    logic [PCW-1:0] exe_pc, front_pc, id_pc;
    logic [NC-1:0]  id_stall;
    logic           exe_v, dump_busy, dump_v;
    logic [CAW-1:0] exe_cause, dump_cause;
    logic [PCW-1:0] exe_bpc;
    logic [CW-1:0]  dump_count;

    int checks = 0;
    int errors = 0;

    bit             m_id_v, m_exe_v, m_busy, m_clr;
    int             m_id_c, m_exe_c, m_idx;
    logic [PCW-1:0] m_id_pc, m_exe_pc;
    int             m_cnt [NC];
    int             obs [NC];
    int             obs_cause [NC];
    int             expd [NC];

    vanilla_exe_bubble_profiler #(.pc_width_p(PCW), .num_cause_p(NC), .ctr_width_p(CW)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .stall_all_i(stall_all),
        .exe_redirect_v_i(redir_v), .exe_redirect_cause_i(redir_cause), .exe_pc_i(exe_pc),
        .front_bubble_v_i(front_v), .front_bubble_cause_i(front_cause), .front_bubble_pc_i(front_pc),
        .id_stall_i(id_stall), .id_pc_i(id_pc),
        .exe_bubble_v_o(exe_v), .exe_bubble_cause_o(exe_cause), .exe_bubble_pc_o(exe_bpc),
        .dump_req_i(dump_req), .dump_clear_i(dump_clear), .dump_busy_o(dump_busy),
        .dump_v_o(dump_v), .dump_cause_o(dump_cause), .dump_count_o(dump_count),
        .dump_yumi_i(dump_yumi)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        stall_all = 0; redir_v = 0; front_v = 0; dump_req = 0; dump_clear = 0; dump_yumi = 0;
        redir_cause = 0; front_cause = 0; exe_pc = 0; front_pc = 0; id_stall = 0; id_pc = 0;
    endtask

    task automatic model_reset();
        m_id_v = 0; m_exe_v = 0; m_busy = 0; m_clr = 0;
        m_id_c = 0; m_exe_c = 0; m_idx = 0; m_id_pc = 0; m_exe_pc = 0;
        for (int k = 0; k < NC; k++) m_cnt[k] = 0;
    endtask

    // Advance one clock; the reference model follows the behavioural rules on the pre-edge inputs
    task automatic cycle();
        bit             nid_v, nex_v, inc, nbusy, nclr;
        int             nid_c, nex_c, ic, low, nidx;
        logic [PCW-1:0] nid_pc, nex_pc;
        int             n_cnt [NC];
        nid_v = m_id_v; nid_c = m_id_c; nid_pc = m_id_pc;
        nex_v = m_exe_v; nex_c = m_exe_c; nex_pc = m_exe_pc;
        nbusy = m_busy; nclr = m_clr; nidx = m_idx;
        n_cnt = m_cnt;
        inc = 0; ic = 0; low = -1;
        for (int k = 0; k < NC; k++) if (id_stall[k] && low < 0) low = k;
        if (!stall_all) begin
            inc = m_exe_v; ic = m_exe_c;
            if (redir_v) begin
                nid_v = 1; nid_c = int'(redir_cause); nid_pc = exe_pc;
                nex_v = 1; nex_c = int'(redir_cause); nex_pc = exe_pc;
            end else begin
                if (front_v) begin nid_v = 1; nid_c = int'(front_cause); nid_pc = front_pc; end
                else begin nid_v = 0; nid_c = 0; nid_pc = 0; end
                if (m_id_v) begin nex_v = 1; nex_c = m_id_c; nex_pc = m_id_pc; end
                else if (low >= 0) begin nex_v = 1; nex_c = low; nex_pc = id_pc; end
                else begin nex_v = 0; nex_c = 0; nex_pc = 0; end
            end
        end
        if (inc && n_cnt[ic] < SAT) n_cnt[ic] = n_cnt[ic] + 1;
        if (m_busy) begin
            if (dump_yumi) begin
                if (m_clr) n_cnt[m_idx] = (inc && ic == m_idx) ? 1 : 0;
                if (m_idx == NC - 1) begin nbusy = 0; nidx = 0; end
                else nidx = m_idx + 1;
            end
        end else if (dump_req) begin
            nbusy = 1; nidx = 0; nclr = dump_clear;
        end
        @(posedge clk);
        #1;
        m_id_v = nid_v; m_id_c = nid_c; m_id_pc = nid_pc;
        m_exe_v = nex_v; m_exe_c = nex_c; m_exe_pc = nex_pc;
        m_busy = nbusy; m_clr = nclr; m_idx = nidx;
        m_cnt = n_cnt;
    endtask

    // Walks the whole dump, recording what the port presented and what the model holds
    task automatic read_counters(input bit clr);
        dump_req = 1; dump_clear = clr;
        cycle();
        dump_req = 0; dump_clear = 0;
        for (int i = 0; i < NC; i++) begin
            expd[i] = m_cnt[m_idx];
            obs[i] = int'(dump_count);
            obs_cause[i] = int'(dump_cause);
            dump_yumi = 1;
            cycle();
            dump_yumi = 0;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset_ni = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({exe_v, exe_cause, exe_bpc, dump_busy, dump_v, dump_cause, dump_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0d cause=%0d pc=%h busy=%0d dv=%0d dc=%0d cnt=%0d, required all 0",
                     exe_v, exe_cause, exe_bpc, dump_busy, dump_v, dump_cause, dump_count);
        end
        reset_ni = 1;
        cycle();
    endtask

    task automatic test_id_stall();
        drive_idle();
        id_stall = 24'h000030; id_pc = 32'h100;
        cycle();
        id_stall = 0; id_pc = 0;
        checks++;
        if (exe_v !== 1'b1 || exe_cause !== 5'd4 || exe_bpc !== 32'h100) begin
            errors++;
            $display("FAIL id_stall_exe: got v=%0d cause=%0d pc=%h, required v=1 cause=4 pc=100", exe_v, exe_cause, exe_bpc);
        end
        cycle();
        stall_all = 1;
        read_counters(1);
        checks++;
        if (obs[4] != 1) begin
            errors++;
            $display("FAIL id_stall_count: got %0d, required 1", obs[4]);
        end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (obs[i] != expd[i] || obs_cause[i] != i) begin
                errors++;
                $display("FAIL id_stall_dump[%0d]: got cause=%0d cnt=%0d, required cause=%0d cnt=%0d", i, obs_cause[i], obs[i], i, expd[i]);
            end
        end
    endtask

    task automatic test_front_vs_redirect();
        drive_idle();
        front_v = 1; front_cause = 2; front_pc = 32'h200;
        cycle();
        front_v = 0; redir_v = 1; redir_cause = 0; exe_pc = 32'h300;
        cycle();
        redir_v = 0;
        checks++;
        if (exe_v !== 1'b1 || exe_cause !== 5'd0 || exe_bpc !== 32'h300) begin
            errors++;
            $display("FAIL redirect_over_front: got v=%0d cause=%0d pc=%h, required v=1 cause=0 pc=300", exe_v, exe_cause, exe_bpc);
        end
        repeat (3) cycle();
        stall_all = 1;
        read_counters(1);
        checks++;
        if (obs[2] != 0 || obs[2] != expd[2]) begin
            errors++;
            $display("FAIL front_not_counted: got %0d, required 0", obs[2]);
        end
        checks++;
        if (obs[0] != expd[0]) begin
            errors++;
            $display("FAIL redirect_count: got %0d, required %0d", obs[0], expd[0]);
        end
    endtask

    task automatic test_stall_all();
        drive_idle();
        id_stall = 24'h80; id_pc = 32'h700;
        cycle();
        id_stall = 0; stall_all = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (exe_v !== 1'b1 || exe_cause !== 5'd7 || exe_bpc !== 32'h700) begin
                errors++;
                $display("FAIL stall_frozen: got v=%0d cause=%0d pc=%h, required v=1 cause=7 pc=700", exe_v, exe_cause, exe_bpc);
            end
        end
        stall_all = 0; id_stall = 24'h80;
        repeat (3) cycle();
        stall_all = 1; id_stall = 0;
        read_counters(1);
        checks++;
        if (obs[7] != 3 || expd[7] != 3) begin
            errors++;
            $display("FAIL stall_count: got %0d model %0d, required 3", obs[7], expd[7]);
        end
    endtask

    task automatic test_saturation();
        drive_idle();
        id_stall = 24'h2; id_pc = 32'h40;
        repeat (20) cycle();
        stall_all = 1; id_stall = 0;
        read_counters(1);
        checks++;
        if (obs[1] != SAT) begin
            errors++;
            $display("FAIL saturate: got %0d, required %0d", obs[1], SAT);
        end
    endtask

    task automatic test_dump_clear();
        int exp_i;
        drive_idle();
        id_stall = 24'h20; id_pc = 32'h500;
        cycle();
        dump_req = 1; dump_clear = 1;
        cycle();
        dump_req = 0; dump_clear = 0;
        exp_i = 0;
        for (int n = 0; n < 100 && m_busy; n++) begin
            checks++;
            if (dump_v !== 1'b1 || int'(dump_cause) != exp_i || dump_count !== CW'(m_cnt[m_idx])) begin
                errors++;
                $display("FAIL dump_entry: got v=%0d cause=%0d cnt=%0d, required v=1 cause=%0d cnt=%0d",
                         dump_v, dump_cause, dump_count, exp_i, m_cnt[m_idx]);
            end
            dump_yumi = n[0];
            dump_req = (n == 7);
            if (n[0]) exp_i++;
            cycle();
            dump_yumi = 0; dump_req = 0;
        end
        checks++;
        if (m_busy || dump_busy !== 1'b0 || dump_v !== 1'b0 || exp_i != NC) begin
            errors++;
            $display("FAIL dump_end: got busy=%0d v=%0d entries=%0d, required busy=0 v=0 entries=%0d", dump_busy, dump_v, exp_i, NC);
        end
        stall_all = 1; id_stall = 0;
        read_counters(1);
        for (int i = 0; i < NC; i++) begin
            checks++;
            if ((i != 5 && obs[i] != 0) || obs[i] != expd[i]) begin
                errors++;
                $display("FAIL dump_clear[%0d]: got %0d, required %0d", i, obs[i], (i == 5) ? expd[i] : 0);
            end
        end
    endtask

    task automatic test_random();
        drive_idle();
        for (int n = 0; n < 600; n++) begin
            stall_all   = ($urandom % 6) == 0;
            redir_v     = ($urandom % 7) == 0;
            redir_cause = CAW'($urandom_range(0, NC - 1));
            exe_pc      = $urandom;
            front_v     = ($urandom % 4) == 0;
            front_cause = CAW'($urandom_range(0, NC - 1));
            front_pc    = $urandom;
            id_stall    = (($urandom % 3) == 0) ? NC'($urandom & $urandom) : '0;
            id_pc       = $urandom;
            dump_req    = !m_busy && (($urandom % 15) == 0);
            dump_clear  = $urandom % 2;
            dump_yumi   = m_busy && (($urandom % 3) != 0);
            checks++;
            if (exe_v !== m_exe_v || int'(exe_cause) != m_exe_c || exe_bpc !== m_exe_pc) begin
                errors++;
                $display("FAIL rand_exe@%0d: got v=%0d cause=%0d pc=%h, required v=%0d cause=%0d pc=%h",
                         n, exe_v, exe_cause, exe_bpc, m_exe_v, m_exe_c, m_exe_pc);
            end
            checks++;
            if (dump_v !== m_busy || dump_busy !== m_busy || int'(dump_cause) != (m_busy ? m_idx : 0)
                || dump_count !== (m_busy ? CW'(m_cnt[m_idx]) : CW'(0))) begin
                errors++;
                $display("FAIL rand_dump@%0d: got v=%0d cause=%0d cnt=%0d, required v=%0d cause=%0d cnt=%0d",
                         n, dump_v, dump_cause, dump_count, m_busy, m_busy ? m_idx : 0, m_busy ? m_cnt[m_idx] : 0);
            end
            cycle();
        end
        drive_idle();
        dump_yumi = 1;
        for (int n = 0; n < 40 && m_busy; n++) cycle();
        dump_yumi = 0;
    endtask

    task automatic test_reset_mid_dump();
        drive_idle();
        id_stall = 24'h8; id_pc = 32'h80;
        repeat (4) cycle();
        id_stall = 0;
        dump_req = 1;
        cycle();
        dump_req = 0;
        dump_yumi = 1;
        repeat (10) cycle();
        dump_yumi = 0;
        checks++;
        if (dump_cause !== 5'd10 || dump_v !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_idx: got v=%0d cause=%0d, required v=1 cause=10", dump_v, dump_cause);
        end
        #2 reset_ni = 0;
        #1;
        model_reset();
        checks++;
        if (dump_v !== 1'b0 || dump_busy !== 1'b0 || exe_v !== 1'b0 || dump_count !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%0d busy=%0d exe_v=%0d cnt=%0d, required all 0", dump_v, dump_busy, exe_v, dump_count);
        end
        @(posedge clk);
        #1 reset_ni = 1;
        read_counters(0);
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (obs[i] != 0) begin
                errors++;
                $display("FAIL reset_counter[%0d]: got %0d, required 0", i, obs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_id_stall();
        test_front_vs_redirect();
        test_stall_all();
        test_saturation();
        test_dump_clear();
        test_random();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
